bus_owner_ctrl: RTL and testbench

- Sequential bus-ownership controller for the 4-master bus.
- Wraps the combinational fixed-priority arbiter (R[0] > R[1] > R[2] > R[3]).
  - Upstream: presents masked requests to the arbiter.
  - Downstream: consumes the arbiter's avbl/grant/grant_num and registers a held bus grant.
- The owner keeps the bus until it drops its request or exceeds a hold limit.
- Timed-out masters are masked out of arbitration until they deassert, which keeps R[0] from starving lower masters.

---
 rtl/bus_arb_pkg.sv | 19 +
 rtl/hold_timer.sv | 38 +++
 rtl/bus_owner_ctrl.sv | 139 +++++++++++++
 tb/tb_bus_owner_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types for the 4-master bus: master ids, ownership FSM states, one-hot helper.
// Pure declarations, no logic of its own.
package bus_arb_pkg;

  localparam int N_MASTERS = 4;

  typedef logic [1:0] master_id_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic logic [N_MASTERS-1:0] onehot4(input master_id_t id);
    return 4'b0001 << id;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Counts cycles of bus ownership; expired is high in the MAX_HOLD-th owned cycle.
// Zero latency on expired (decoded from the count register); no backpressure.
module hold_timer #(
  parameter int MAX_HOLD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(MAX_HOLD);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // clear wins over run so the count is back at zero before the next ownership starts
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CW'(MAX_HOLD - 1));

endmodule

// File: rtl/bus_owner_ctrl.sv
// Holds the bus for the arbiter's winner until it drops req or hits MAX_HOLD, then one turnaround cycle.
// Grant registered one cycle after the arbiter reports a request; timed-out masters are masked until they drop req.
module bus_owner_ctrl
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] arb_req,
  input  logic       avbl_in,
  input  logic [3:0] grant_in,
  input  logic [1:0] grant_num_in,
  output logic [3:0] bus_grant,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout,
  output logic [3:0] tmo_mask,
  output logic       err
);

  state_t     state_q, state_d;
  logic [3:0] bus_grant_q, bus_grant_d;
  master_id_t owner_q, owner_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic [3:0] tmo_mask_q, tmo_mask_d;
  logic       err_q, err_d;

  logic expired;
  logic owner_req;
  logic tmo_fire;

  assign arb_req   = req & ~tmo_mask_q;
  assign owner_req = req[owner_q];
  assign tmo_fire  = (state_q == GRANTED) && owner_req && expired;

  hold_timer #(
    .MAX_HOLD(MAX_HOLD)
  ) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_d != GRANTED),
    .run    (state_q == GRANTED),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A drop of the owner's request outranks the hold limit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!avbl_in) begin
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        if (!owner_req || expired) begin
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_grant_d = bus_grant_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    timeout_d   = 1'b0;
    tmo_mask_d  = tmo_mask_q & req;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (!avbl_in) begin
          owner_d     = grant_num_in;
          bus_grant_d = onehot4(grant_num_in);
          busy_d      = 1'b1;
          if (grant_in != onehot4(grant_num_in)) begin
            err_d = 1'b1;
          end
        end else if (arb_req != 4'b0000) begin
          err_d = 1'b1;
        end
      end
      GRANTED: begin
        if (state_d != GRANTED) begin
          bus_grant_d = 4'b0000;
          busy_d      = 1'b0;
        end
        // Set is applied after the clear so it wins for the owner's bit
        if (tmo_fire) begin
          timeout_d           = 1'b1;
          tmo_mask_d[owner_q] = 1'b1;
        end
      end
      default: begin
        bus_grant_d = 4'b0000;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_grant_q <= 4'b0000;
      owner_q     <= 2'd0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      tmo_mask_q  <= 4'b0000;
      err_q       <= 1'b0;
    end else begin
      bus_grant_q <= bus_grant_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      tmo_mask_q  <= tmo_mask_d;
      err_q       <= err_d;
    end
  end

  assign bus_grant = bus_grant_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;
  assign tmo_mask  = tmo_mask_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bus_owner_ctrl.sv
// Bench for bus_owner_ctrl with a fixed-priority arbiter model on its arb_req port,
// checked every cycle against a cycle-level ownership model.
module tb_bus_owner_ctrl;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       force_bad = 1'b0;
  logic [3:0] arb_req;
  logic       avbl_in;
  logic [3:0] grant_in;
  logic [1:0] grant_num_in;
  logic [3:0] bus_grant;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;
  logic [3:0] tmo_mask;
  logic       err;

  int checks   = 0;
  int failures = 0;

  // Ownership model: who holds the bus, for how many cycles, and the turnaround slot
  int         own_m      = -1;
  int         last_own_m = 0;
  int         held_m     = 0;
  bit         turn_m     = 1'b0;
  logic [3:0] mask_m     = 4'b0000;
  bit         tmo_m      = 1'b0;
  bit         err_m      = 1'b0;

  always #5 clk = ~clk;

  bus_owner_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .arb_req     (arb_req),
    .avbl_in     (avbl_in),
    .grant_in    (grant_in),
    .grant_num_in(grant_num_in),
    .bus_grant   (bus_grant),
    .owner       (owner),
    .busy        (busy),
    .timeout     (timeout),
    .tmo_mask    (tmo_mask),
    .err         (err)
  );

  // Fixed-priority arbiter, R[0] highest; force_bad corrupts grant_in to 0010
  always_comb begin
    avbl_in      = (arb_req == 4'b0000);
    grant_num_in = 2'd0;
    grant_in     = 4'b0000;
    for (int i = 3; i >= 0; i--) begin
      if (arb_req[i]) grant_num_in = 2'(i);
    end
    if (!avbl_in) begin
      grant_in = force_bad ? 4'b0010 : (4'b0001 << grant_num_in);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [3:0] r, input logic rr, input logic bad);
    logic [3:0] vis;
    logic [3:0] nmask;
    int w;
    if (rr) begin
      own_m = -1; last_own_m = 0; held_m = 0; turn_m = 1'b0;
      mask_m = 4'b0000; tmo_m = 1'b0; err_m = 1'b0;
      return;
    end
    vis   = r & ~mask_m;
    nmask = mask_m & r;
    tmo_m = 1'b0;
    if (turn_m) begin
      turn_m = 1'b0;
    end else if (own_m >= 0) begin
      if (!r[own_m]) begin
        own_m = -1; turn_m = 1'b1;
      end else if (held_m + 1 == MAX_HOLD) begin
        nmask[own_m] = 1'b1; tmo_m = 1'b1; own_m = -1; turn_m = 1'b1;
      end else begin
        held_m++;
      end
    end else if (vis != 4'b0000) begin
      w = 0;
      for (int i = 3; i >= 0; i--) if (vis[i]) w = i;
      if (bad && w != 1) err_m = 1'b1;
      own_m = w; last_own_m = w; held_m = 0;
    end
    mask_m = nmask;
  endtask

  task automatic step(input logic [3:0] r, input logic rr, input logic bad);
    logic [3:0] exp_g;
    req = r; rst = rr; force_bad = bad;
    @(negedge clk);
    chk("arb_req", 32'(arb_req), 32'(r & ~mask_m));
    model_step(r, rr, bad);
    @(posedge clk);
    #1;
    exp_g = (own_m >= 0) ? (4'b0001 << own_m) : 4'b0000;
    chk("bus_grant", 32'(bus_grant), 32'(exp_g));
    chk("owner",     32'(owner),     32'(last_own_m[1:0]));
    chk("busy",      32'(busy),      32'(own_m >= 0));
    chk("timeout",   32'(timeout),   32'(tmo_m));
    chk("tmo_mask",  32'(tmo_mask),  32'(mask_m));
    chk("err",       32'(err),       32'(err_m));
  endtask

  initial begin
    logic [3:0] r_rand;
    logic       rr_rand;
    logic       bad_rand;
    r_rand = 4'b0000;

    // Reset and idle
    repeat (2) step(4'b0000, 1'b1, 1'b0);
    repeat (10) step(4'b0000, 1'b0, 1'b0);

    // Single grant and release
    repeat (3) step(4'b0100, 1'b0, 1'b0);
    repeat (3) step(4'b0000, 1'b0, 1'b0);

    // Owner keeps the bus against a higher-priority request
    repeat (2) step(4'b0100, 1'b0, 1'b0);
    repeat (3) step(4'b0101, 1'b0, 1'b0);
    repeat (4) step(4'b0001, 1'b0, 1'b0);
    repeat (2) step(4'b0000, 1'b0, 1'b0);

    // Timeout, masking, and all-masked idling
    repeat (14) step(4'b0011, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    repeat (2) step(4'b0000, 1'b0, 1'b0);

    // Drop exactly on the limit cycle
    repeat (4) step(4'b0100, 1'b0, 1'b0);
    repeat (3) step(4'b0000, 1'b0, 1'b0);

    // Reset in the second owned cycle, then arbiter inconsistency
    repeat (2) step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b1);
    repeat (6) step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // Random traffic with occasional resets and corrupted grants
    repeat (500) begin
      if ($urandom_range(0, 2) == 0) r_rand = 4'($urandom);
      rr_rand  = ($urandom_range(0, 99) == 0);
      bad_rand = ($urandom_range(0, 39) == 0);
      step(r_rand, rr_rand, bad_rand);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
